// File: rtl/fpna_bitstream_loader.sv
// Serial configuration-chain loader: shifts bytes MSB-first onto the chain head
// with one enable strobe per bit, and returns the bits leaving the chain tail as readback bytes.
module fpna_bitstream_loader #(
  parameter int BS_BITS = 256,
  parameter int DIV     = 0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_in_data,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic       o_bs_in,
  output logic       o_config_en,
  input  logic       i_bs_out,
  output logic [7:0] o_rb_data,
  output logic       o_rb_valid,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CW = $clog2(BS_BITS + 1);
  localparam int DW = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(BS_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [7:0]    r_sreg;
  logic [CW-1:0] r_bit_cnt;
  logic [3:0]    r_bidx;
  logic [DW-1:0] r_div;
  logic [7:0]    r_rb_byte;
  logic [3:0]    r_rb_cnt;
  logic [7:0]    r_rb_data;
  logic          r_rb_valid;
  logic          r_config_en;
  logic          r_in_ready;
  logic          r_busy;
  logic          r_done;

  logic [1:0]    w_state_nxt;
  logic [7:0]    w_sreg_nxt;
  logic [CW-1:0] w_bit_cnt_nxt;
  logic [3:0]    w_bidx_nxt;
  logic [DW-1:0] w_div_nxt;
  logic [7:0]    w_rb_byte_nxt;
  logic [3:0]    w_rb_cnt_nxt;
  logic [7:0]    w_rb_data_nxt;
  logic          w_rb_valid_nxt;
  logic [7:0]    w_rb_shift;
  logic [3:0]    w_rb_cnt_inc;
  logic [CW-1:0] w_bit_cnt_inc;
  logic [3:0]    w_bidx_inc;

  // Next-state and datapath update for the load session.
  always_comb begin
    w_state_nxt    = r_state;
    w_sreg_nxt     = r_sreg;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_bidx_nxt     = r_bidx;
    w_div_nxt      = r_div;
    w_rb_byte_nxt  = r_rb_byte;
    w_rb_cnt_nxt   = r_rb_cnt;
    w_rb_data_nxt  = r_rb_data;
    w_rb_valid_nxt = 1'b0;
    w_rb_shift     = {r_rb_byte[6:0], i_bs_out};
    w_rb_cnt_inc   = r_rb_cnt + 4'd1;
    w_bit_cnt_inc  = r_bit_cnt + CW'(1);
    w_bidx_inc     = r_bidx + 4'd1;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt   = S_WAIT;
          w_bit_cnt_nxt = '0;
          w_rb_cnt_nxt  = 4'd0;
          w_rb_byte_nxt = 8'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_WAIT: begin
        if (i_in_valid) begin
          w_sreg_nxt  = i_in_data;
          w_bidx_nxt  = 4'd0;
          w_div_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_SHIFT: begin
        if (r_div == DIV_LAST) begin
          w_sreg_nxt    = {r_sreg[6:0], 1'b0};
          w_rb_byte_nxt = w_rb_shift;
          w_rb_cnt_nxt  = w_rb_cnt_inc;
          w_bit_cnt_nxt = w_bit_cnt_inc;
          w_bidx_nxt    = w_bidx_inc;
          w_div_nxt     = '0;
          if (w_rb_cnt_inc == 4'd8) begin
            w_rb_data_nxt  = w_rb_shift;
            w_rb_valid_nxt = 1'b1;
            w_rb_cnt_nxt   = 4'd0;
          end else begin
            w_rb_valid_nxt = 1'b0;
          end
          if (w_bit_cnt_inc == BIT_LAST) begin
            w_state_nxt = S_DONE;
            // A trailing partial byte is flushed left-justified.
            if (w_rb_cnt_inc != 4'd8) begin
              w_rb_data_nxt  = w_rb_shift << (4'd8 - w_rb_cnt_inc);
              w_rb_valid_nxt = 1'b1;
            end else begin
              w_rb_valid_nxt = 1'b1;
            end
          end else if (w_bidx_inc == 4'd8) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end else begin
          w_div_nxt = r_div + DW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_sreg      <= 8'd0;
      r_bit_cnt   <= '0;
      r_bidx      <= 4'd0;
      r_div       <= '0;
      r_rb_byte   <= 8'd0;
      r_rb_cnt    <= 4'd0;
      r_rb_data   <= 8'd0;
      r_rb_valid  <= 1'b0;
      r_config_en <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sreg      <= w_sreg_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_bidx      <= w_bidx_nxt;
      r_div       <= w_div_nxt;
      r_rb_byte   <= w_rb_byte_nxt;
      r_rb_cnt    <= w_rb_cnt_nxt;
      r_rb_data   <= w_rb_data_nxt;
      r_rb_valid  <= w_rb_valid_nxt;
      r_config_en <= (w_state_nxt == S_SHIFT) && (w_div_nxt == DIV_LAST);
      r_in_ready  <= (w_state_nxt == S_WAIT);
      r_busy      <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_SHIFT);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_bs_in     = r_sreg[7];
  assign o_config_en = r_config_en;
  assign o_rb_data   = r_rb_data;
  assign o_rb_valid  = r_rb_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_fpna_bitstream_loader.sv
// Bench for fpna_bitstream_loader: two instances (16 bits / DIV 0 and 12 bits / DIV 3)
// each driving a behavioural chain; streams and readback compared against a session model.
module tb_fpna_bitstream_loader;

  localparam int BSA = 16;
  localparam int DIVA = 0;
  localparam int BSB = 12;
  localparam int DIVB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start[2] = '{1'b0, 1'b0};
  logic [7:0] in_data[2] = '{8'd0, 8'd0};
  logic       in_valid[2] = '{1'b0, 1'b0};
  logic       in_ready[2], bs_in[2], config_en[2], rb_valid[2], busy[2], done[2], bs_out[2];
  logic [7:0] rb_data[2];

  logic [63:0] chain[2] = '{64'd0, 64'd0};
  logic [15:0] prev_stream[2] = '{16'd0, 16'd0};

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic       sent_bits[2][0:255];
  int         strobe_cyc[2][0:255];
  int         n_sent[2] = '{0, 0};
  logic [7:0] rb_got[2][0:63];
  int         n_rb[2] = '{0, 0};
  int         unstable[2] = '{0, 0};
  logic       prev_bs_in[2] = '{1'b0, 1'b0};
  logic       prev_stb[2] = '{1'b0, 1'b0};
  logic       prev_take[2] = '{1'b0, 1'b0};

  fpna_bitstream_loader #(.BS_BITS(BSA), .DIV(DIVA)) u_a (
    .i_clk(clk), .i_reset(reset), .i_start(start[0]), .i_in_data(in_data[0]),
    .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]), .o_bs_in(bs_in[0]),
    .o_config_en(config_en[0]), .i_bs_out(bs_out[0]), .o_rb_data(rb_data[0]),
    .o_rb_valid(rb_valid[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  fpna_bitstream_loader #(.BS_BITS(BSB), .DIV(DIVB)) u_b (
    .i_clk(clk), .i_reset(reset), .i_start(start[1]), .i_in_data(in_data[1]),
    .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]), .o_bs_in(bs_in[1]),
    .o_config_en(config_en[1]), .i_bs_out(bs_out[1]), .o_rb_data(rb_data[1]),
    .o_rb_valid(rb_valid[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  // Behavioural chains: shift on config_en, tail bit fed back as bs_out.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (config_en[k] === 1'b1) chain[k] <= {chain[k][62:0], bs_in[k]};
    end
  end
  assign bs_out[0] = chain[0][BSA-1];
  assign bs_out[1] = chain[1][BSB-1];

  // Mid-cycle monitor: records strobed bits, readback bytes and bs_in glitches.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (config_en[k] === 1'b1 && n_sent[k] < 256) begin
        sent_bits[k][n_sent[k]] = bs_in[k];
        strobe_cyc[k][n_sent[k]] = cyc;
        n_sent[k] = n_sent[k] + 1;
      end
      if (rb_valid[k] === 1'b1 && n_rb[k] < 64) begin
        rb_got[k][n_rb[k]] = rb_data[k];
        n_rb[k] = n_rb[k] + 1;
      end
      if (bs_in[k] !== prev_bs_in[k] && !prev_stb[k] && !prev_take[k]) unstable[k] = unstable[k] + 1;
      prev_bs_in[k] = bs_in[k];
      prev_stb[k] = (config_en[k] === 1'b1);
      prev_take[k] = (in_ready[k] === 1'b1) && (in_valid[k] === 1'b1);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic session(input int k, input logic [7:0] b0, input logic [7:0] b1,
                         input int gap, input bit poke);
    int bs, dv, s0, r0, u0, nbytes, t, viol;
    bit got;
    logic [15:0] cur, obs_stream, exp_stream;
    bs = (k == 0) ? BSA : BSB;
    dv = (k == 0) ? DIVA : DIVB;
    s0 = n_sent[k];
    r0 = n_rb[k];
    u0 = unstable[k];
    cur = {b0, b1};
    start[k] = 1'b1;
    tick;
    start[k] = 1'b0;
    chk("busy_after_start", 64'(busy[k]), 64'd1);
    chk("done_cleared", 64'(done[k]), 64'd0);
    for (int j = 0; j < 2; j++) begin
      if (j == 1) repeat (gap) tick;
      in_data[k] = (j == 0) ? b0 : b1;
      in_valid[k] = 1'b1;
      got = 1'b0;
      for (t = 0; t < 100 && !got; t++) begin
        if (in_ready[k] === 1'b1) got = 1'b1;
        tick;
      end
      in_valid[k] = 1'b0;
      chk("handshake", 64'(got), 64'd1);
      if (poke && j == 0) begin
        start[k] = 1'b1;
        in_valid[k] = 1'b1;
        in_data[k] = ~b1;
        chk("no_ready_in_shift", 64'(in_ready[k]), 64'd0);
        tick;
        start[k] = 1'b0;
        tick;
        in_valid[k] = 1'b0;
      end
    end
    t = 0;
    while (done[k] !== 1'b1 && t < 400) begin
      tick;
      t++;
    end
    chk("done_reached", 64'(done[k]), 64'd1);
    tick;
    tick;
    chk("shift_count", 64'(n_sent[k] - s0), 64'(bs));
    // Reference: first bs bits of the byte stream, MSB-first, unsent bits zero.
    exp_stream = (cur >> (16 - bs)) << (16 - bs);
    obs_stream = 16'd0;
    for (int i = 0; i < bs; i++) obs_stream[15-i] = sent_bits[k][s0+i];
    chk("bs_in_stream", 64'(obs_stream), 64'(exp_stream));
    viol = 0;
    for (int i = 1; i < bs; i++) begin
      if ((i % 8) != 0 && (strobe_cyc[k][s0+i] - strobe_cyc[k][s0+i-1]) != dv + 1) viol++;
    end
    chk("strobe_spacing", 64'(viol), 64'd0);
    chk("bs_in_stable", 64'(unstable[k] - u0), 64'd0);
    nbytes = (bs + 7) / 8;
    chk("rb_count", 64'(n_rb[k] - r0), 64'(nbytes));
    for (int m = 0; m < nbytes; m++) begin
      chk("rb_byte", 64'(rb_got[k][r0+m]), 64'(prev_stream[k][15-8*m -: 8]));
    end
    chk("chain_content", chain[k] & ((64'd1 << bs) - 64'd1), 64'(exp_stream >> (16 - bs)));
    chk("busy_end", 64'(busy[k]), 64'd0);
    chk("ready_end", 64'(in_ready[k]), 64'd0);
    prev_stream[k] = exp_stream;
  endtask

  initial begin
    int t;
    bit got;
    repeat (3) tick;
    for (int k = 0; k < 2; k++) begin
      chk("reset_outputs", {51'd0, in_ready[k], bs_in[k], config_en[k], rb_valid[k],
                            busy[k], done[k], rb_data[k]}, 64'd0);
    end
    reset = 1'b0;
    tick;

    session(0, 8'hA5, 8'h3C, 0, 1'b0);
    session(0, 8'hFF, 8'h00, 3, 1'b1);
    session(1, 8'hF0, 8'hAB, 5, 1'b0);
    session(1, 8'($urandom), 8'($urandom), $urandom_range(0, 5), 1'b1);
    session(1, 8'($urandom), 8'($urandom), $urandom_range(0, 5), 1'b0);
    session(0, 8'($urandom), 8'($urandom), $urandom_range(0, 5), 1'b1);
    session(0, 8'($urandom), 8'($urandom), $urandom_range(0, 5), 1'b0);

    // Mid-session reset on instance A while shifting 0xFF.
    start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    in_data[0] = 8'hFF;
    in_valid[0] = 1'b1;
    got = 1'b0;
    for (t = 0; t < 50 && !got; t++) begin
      if (in_ready[0] === 1'b1) got = 1'b1;
      tick;
    end
    in_valid[0] = 1'b0;
    chk("rst_handshake", 64'(got), 64'd1);
    tick;
    chk("pre_reset_strobe", {62'd0, config_en[0], busy[0]}, 64'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {51'd0, in_ready[0], bs_in[0], config_en[0], rb_valid[0],
                                busy[0], done[0], rb_data[0]}, 64'd0);
    tick;
    reset = 1'b0;
    tick;
    chk("idle_after_reset", {62'd0, busy[0], config_en[0]}, 64'd0);
    start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    chk("busy_after_reset_start", 64'(busy[0]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpna_bitstream_loader.md
# fpna_bitstream_loader

Configuration-stream transmitter for the neurochip's serial bitstream chain. It accepts configuration bytes over a valid/ready handshake and serializes them MSB-first onto the chain's `bs_in`. It pulses `config_en` exactly once per bit, so the chain shifts exactly `BS_BITS` times per session. It also captures the bits falling out of the chain tail (`bs_out`) and returns them as readback bytes, so the previous configuration can be verified while the new one is loaded.

## Interface

Parameters:
- `BS_BITS`, default 256: chain length in bits, and the number of shifts per session; must be ≥ 8.
- `DIV`, default 0: strobe spacing. One `config_en` pulse every `DIV+1` cycles in SHIFT.

Ports:
- `clk`  in  1  clock. The loader and the chain share this clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a load session. Honoured only in IDLE or DONE.
- `in_data`  in  8  configuration byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the loader accepts a byte this cycle.
- `bs_in`  out  1  serial data to the chain head.
- `config_en`  out  1  chain shift enable, one-cycle pulse per bit.
- `bs_out`  in  1  chain tail bit.
- `rb_data`  out  8  readback byte, MSB = earliest bit captured.
- `rb_valid`  out  1  one-cycle pulse; `rb_data` is valid. There is no backpressure.
- `busy`  out  1  high in WAIT_BYTE and SHIFT.
- `done`  out  1  sticky high in DONE; cleared by `start` or `reset`.

## Operation

States: IDLE, WAIT_BYTE, SHIFT, DONE.

- **IDLE / DONE**
  - `start`=1 → WAIT_BYTE. Bit counter, readback counter and readback byte are cleared.
  - `in_valid` is ignored.
- **WAIT_BYTE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: load `in_data` into the shift register, clear the byte-bit index and divider → SHIFT.
- **SHIFT**
  - `in_ready`=0.
  - The divider counts 0..`DIV`. The strobe cycle is the cycle where divider == `DIV`.
  - On the strobe cycle, `config_en`=1 and `bs_in` = shift-register MSB.
  - At the strobe edge:
    - the shift register shifts left;
    - `bs_out` is sampled into the readback byte, MSB-first;
    - the bit counter and byte-bit index increment.
- **Transitions after a strobe**
  - Bit counter reaches `BS_BITS` → DONE. Any unsent bits of the current byte are discarded.
  - Otherwise, byte-bit index reaches 8 → WAIT_BYTE.
- **Readback**
  - After every 8th sampled bit, `rb_data` updates and `rb_valid` pulses in the following cycle.
  - If `BS_BITS` is not a multiple of 8, the final partial byte is emitted on entry to DONE, left-justified with low bits zero.
- **Stream order**
  - The first bit sent ends at the chain tail.
  - Reloading therefore reads back the previous session's stream in its original order.
- **Ignored events**
  - `start` in WAIT_BYTE or SHIFT has no effect.
  - `in_valid` with `in_ready`=0 has no effect and consumes nothing.
- **Counter width**: the bit counter is `$clog2(BS_BITS+1)` bits. It never wraps within a session.

## Timing

- **Reset values**: all outputs 0; state IDLE; all counters 0.
- **Reset mid-session**: immediate return to IDLE, `config_en` drops asynchronously. The chain holds a partial, undefined configuration; only a new `start` recovers it.
- **Handshake to first strobe**: the cycle after the handshake is the first SHIFT cycle. The first strobe occurs `DIV` cycles later, so with `DIV`=0 it lands in that same cycle.
- **Per-byte cost**: 8·(`DIV`+1) SHIFT cycles plus 1 WAIT_BYTE cycle minimum. A full byte with `DIV`=0 takes 9 cycles.
- **Idle gaps**: `config_en` is low in every non-strobe cycle. Gaps from a stalled `in_valid` add no shifts.
- **bs_in stability**: `bs_in` changes only at strobe edges or on a byte load. It is stable for the whole cycle in which `config_en`=1.
- **start in DONE**: `done` falls in the cycle after `start` is sampled.
- **rb_valid relative to the 8th strobe**: `rb_valid` rises 1 cycle after the 8th strobe of each byte.

## Test plan

- **Reset**: assert `reset` mid-cycle → all outputs 0 asynchronously; `in_ready`=0; `start` after release → `busy`=1 next cycle.
- **Basic load** (`BS_BITS`=16, `DIV`=0): start, send 0xA5 then 0x3C → exactly 16 `config_en` pulses; `bs_in` sequence 1010_0101_0011_1100; `done`=1; `busy`=0.
- **Readback** (behavioural chain model attached): second session sending 0xFF, 0x00 → `rb_valid` pulses twice with `rb_data` = 0xA5, then 0x3C; chain then holds the 0xFF, 0x00 stream.
- **Divider and stalls** (`DIV`=3): strobes spaced exactly 4 cycles, `bs_in` stable between them; hold `in_valid` low 5 cycles between bytes → no extra `config_en`, total still `BS_BITS`.
- **Partial byte** (`BS_BITS`=12): send 0xF0, 0xAB → 12 strobes, `bs_in` = 1111_0000_1010, low nibble of 0xAB dropped; final `rb_data` has low nibble zero.
- **Ignored events and mid-session reset**: `start` pulsed during SHIFT is ignored; `in_valid` during SHIFT consumes no byte; `reset` in SHIFT → IDLE, `done`=0, `config_en`=0.
